// File: rtl/cpu_led_seq_pkg.sv
// Shared register offsets, mode/state/direction encodings for the LED sequencer.
package cpu_led_seq_pkg;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_SEED    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_WALK   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/cpu_led_seq_next.sv
// Next LED pattern and bounce direction from the current pattern and mode.
// Purely combinational; no latency, no flow control.
module cpu_led_seq_next
  import cpu_led_seq_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic [LED_W-1:0] cur,
  input  mode_e            mode,
  input  dir_e             dir,
  input  logic [LED_W-1:0] seed,
  output logic [LED_W-1:0] next_pattern,
  output dir_e             next_dir
);

  always_comb begin
    next_pattern = cur;
    next_dir     = dir;
    case (mode)
      MODE_STATIC: next_pattern = seed;
      MODE_WALK:   next_pattern = {cur[LED_W-2:0], cur[LED_W-1]};
      MODE_BLINK:  next_pattern = ~cur;
      MODE_BOUNCE: begin
        // Reverse when the lit edge bit would fall off in the current direction.
        if ((dir == DIR_LEFT && !cur[LED_W-1]) || (dir == DIR_RIGHT && cur[0])) begin
          next_pattern = cur << 1;
          next_dir     = DIR_LEFT;
        end else begin
          next_pattern = cur >> 1;
          next_dir     = DIR_RIGHT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_led_sequencer.sv
// Avalon-MM LED sequencer: config slave plus a master that writes patterns to PIO offset 0.
// Accept-to-accept spacing is max(PERIOD,1)+1 cycles; the request is held through m_waitrequest.
module cpu_led_sequencer
  import cpu_led_seq_pkg::*;
#(
  parameter int LED_W          = 8,
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        s_address,
  input  logic              s_chipselect,
  input  logic              s_write_n,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic [LED_W-1:0]  pattern
);

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

  state_e              state, state_nxt;
  logic                enable;
  mode_e               mode;
  logic [PERIOD_W-1:0] period;
  logic [LED_W-1:0]    seed;
  logic [LED_W-1:0]    cur;
  dir_e                dir;
  logic [PERIOD_W-1:0] cnt;
  logic                oneshot;

  logic [LED_W-1:0]    next_cur;
  dir_e                next_dir;
  logic [PERIOD_W-1:0] period_eff;

  logic cfg_wr, ctl_wr, push, en_rise;
  logic do_start, do_accept, do_advance, cnt_dec, set_oneshot, clr_oneshot;
  logic unused_wdata;

  assign cfg_wr       = s_chipselect & ~s_write_n;
  assign ctl_wr       = cfg_wr && (s_address == REG_CONTROL);
  assign push         = cfg_wr && (s_address == REG_STATUS);
  assign en_rise      = ctl_wr & s_writedata[0] & ~enable;
  assign period_eff   = (period == '0) ? CNT_ONE : period;
  assign unused_wdata = ^s_writedata;

  cpu_led_seq_next #(.LED_W(LED_W)) u_next (
    .cur          (cur),
    .mode         (mode),
    .dir          (dir),
    .seed         (seed),
    .next_pattern (next_cur),
    .next_dir     (next_dir)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    do_start     = 1'b0;
    do_accept    = 1'b0;
    do_advance   = 1'b0;
    cnt_dec      = 1'b0;
    set_oneshot  = 1'b0;
    clr_oneshot  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en_rise) begin
          state_nxt = ST_WRITE;
          do_start  = 1'b1;
        end else if (push) begin
          state_nxt   = ST_WRITE;
          set_oneshot = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          do_accept = 1'b1;
          if (oneshot || !enable) begin
            state_nxt   = ST_IDLE;
            clr_oneshot = 1'b1;
          end else begin
            state_nxt = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_ONE || push) begin
          state_nxt  = ST_WRITE;
          do_advance = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_address    = 2'd0;
    m_chipselect = (state == ST_WRITE);
    m_write_n    = ~m_chipselect;
    m_writedata  = m_chipselect ? {{(32-LED_W){1'b0}}, cur} : 32'd0;
    busy         = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= 1'b0;
      mode    <= MODE_STATIC;
      period  <= PERIOD_W'(DEFAULT_PERIOD);
      seed    <= '0;
      cur     <= '0;
      dir     <= DIR_LEFT;
      cnt     <= '0;
      oneshot <= 1'b0;
      pattern <= '0;
    end else begin
      if (ctl_wr) begin
        enable <= s_writedata[0];
        mode   <= mode_e'(s_writedata[2:1]);
      end
      if (cfg_wr && s_address == REG_PERIOD) period <= s_writedata[PERIOD_W-1:0];
      if (cfg_wr && s_address == REG_SEED)   seed   <= s_writedata[LED_W-1:0];

      if (do_start) begin
        cur <= seed;
        dir <= DIR_LEFT;
      end else if (do_advance) begin
        cur <= next_cur;
        dir <= next_dir;
      end

      if (do_accept) begin
        pattern <= cur;
        cnt     <= period_eff;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_ONE;
      end

      if (set_oneshot)      oneshot <= 1'b1;
      else if (clr_oneshot) oneshot <= 1'b0;
    end
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      REG_CONTROL: s_readdata = {29'd0, mode, enable};
      REG_PERIOD:  s_readdata[PERIOD_W-1:0] = period;
      REG_SEED:    s_readdata[LED_W-1:0] = seed;
      REG_STATUS: begin
        s_readdata[0]          = busy;
        s_readdata[8 +: LED_W] = pattern;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_led_sequencer.sv
// Directed bench for cpu_led_sequencer: one task per scenario, accepts logged at negedge.
module tb_cpu_led_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        busy;
  logic [7:0]  pattern;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] acc_dat[$];
  int          acc_cyc[$];

  cpu_led_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_write_n     (s_write_n),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .pattern       (pattern)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A request visible at negedge with waitrequest low is accepted at the next edge (cyc+1).
  always @(negedge clk) begin
    if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
      acc_dat.push_back(m_writedata);
      acc_cyc.push_back(cyc + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    s_address    = addr;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    s_writedata  = data;
    tick();
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_writedata  = 32'd0;
  endtask

  task automatic clear_log();
    acc_dat.delete();
    acc_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checks++; if (m_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %b need 0", m_chipselect); end
    checks++; if (m_write_n !== 1'b1) begin errors++; $display("FAIL reset_wn got %b need 1", m_write_n); end
    checks++; if (m_writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h need 0", m_writedata); end
    checks++; if (m_address !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d need 0", m_address); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (pattern !== 8'h00) begin errors++; $display("FAIL reset_pattern got %h need 00", pattern); end
    s_address = 2'd0; #1;
    checks++; if (s_readdata !== 32'd0) begin errors++; $display("FAIL reset_control got %h need 0", s_readdata); end
    s_address = 2'd1; #1;
    checks++; if (s_readdata !== 32'd5_000_000) begin errors++; $display("FAIL reset_period got %0d need 5000000", s_readdata); end
    s_address = 2'd2; #1;
    checks++; if (s_readdata !== 32'd0) begin errors++; $display("FAIL reset_seed got %h need 0", s_readdata); end
  endtask

  task automatic test_push_oneshot();
    int c0;
    clear_log();
    cfg_write(2'd3, 32'd0);
    checks++; if (m_chipselect !== 1'b1 || m_writedata !== 32'd0) begin errors++; $display("FAIL push_req got cs=%b d=%h need cs=1 d=0", m_chipselect, m_writedata); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL push_idle got busy=%b need 0", busy); end
    repeat (2) tick();
    checks++; if (acc_dat.size() !== 1) begin errors++; $display("FAIL push_count got %0d need 1", acc_dat.size()); end
    else begin
      checks++; if (acc_dat[0] !== 32'd0) begin errors++; $display("FAIL push_data got %h need 0", acc_dat[0]); end
    end
    cfg_write(2'd2, 32'h77);
    cfg_write(2'd0, 32'h1);
    c0 = cyc;
    tick();
    checks++; if (acc_dat.size() !== 2) begin errors++; $display("FAIL enable_count got %0d need 2", acc_dat.size()); end
    else begin
      checks++; if (acc_dat[1] !== 32'h77) begin errors++; $display("FAIL enable_data got %h need 77", acc_dat[1]); end
      checks++; if (acc_cyc[1] !== c0 + 1) begin errors++; $display("FAIL enable_latency got %0d need %0d", acc_cyc[1], c0 + 1); end
    end
    cfg_write(2'd0, 32'h0);
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL disable_idle got busy=%b need 0", busy); end
    s_address = 2'd3; #1;
    checks++; if (s_readdata !== 32'h0000_7700) begin errors++; $display("FAIL status_read got %h need 00007700", s_readdata); end
  endtask

  task automatic test_walk();
    logic [7:0] exp;
    clear_log();
    cfg_write(2'd1, 32'd4);
    cfg_write(2'd2, 32'h01);
    cfg_write(2'd0, 32'h3);
    repeat (46) tick();
    cfg_write(2'd0, 32'h0);
    repeat (3) tick();
    checks++; if (acc_dat.size() < 9) begin errors++; $display("FAIL walk_count got %0d need >=9", acc_dat.size()); end
    exp = 8'h01;
    for (int i = 0; i < 9 && i < acc_dat.size(); i++) begin
      checks++; if (acc_dat[i] !== {24'd0, exp}) begin errors++; $display("FAIL walk_data[%0d] got %h need %h", i, acc_dat[i], exp); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin errors++; $display("FAIL walk_spacing[%0d] got %0d need 5", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
      exp = {exp[6:0], exp[7]};
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_b [10] = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    clear_log();
    cfg_write(2'd1, 32'd1);
    cfg_write(2'd2, 32'h40);
    cfg_write(2'd0, 32'h5);
    repeat (24) tick();
    cfg_write(2'd0, 32'h0);
    repeat (3) tick();
    checks++; if (acc_dat.size() < 10) begin errors++; $display("FAIL bounce_count got %0d need >=10", acc_dat.size()); end
    for (int i = 0; i < 10 && i < acc_dat.size(); i++) begin
      checks++; if (acc_dat[i] !== {24'd0, exp_b[i]}) begin errors++; $display("FAIL bounce_data[%0d] got %h need %h", i, acc_dat[i], exp_b[i]); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin errors++; $display("FAIL bounce_spacing[%0d] got %0d need 2", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_blink_stall();
    int c0;
    cfg_write(2'd1, 32'd1);
    cfg_write(2'd2, 32'hA5);
    clear_log();
    cfg_write(2'd0, 32'h7);
    c0 = cyc;
    repeat (2) tick();
    m_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (m_chipselect !== 1'b1) begin errors++; $display("FAIL stall_cs[%0d] got %b need 1", k, m_chipselect); end
      checks++; if (m_writedata !== 32'h5A) begin errors++; $display("FAIL stall_data[%0d] got %h need 5a", k, m_writedata); end
      tick();
    end
    m_waitrequest = 1'b0;
    repeat (3) tick();
    cfg_write(2'd0, 32'h0);
    repeat (3) tick();
    checks++; if (acc_dat.size() < 3) begin errors++; $display("FAIL blink_count got %0d need >=3", acc_dat.size()); end
    else begin
      checks++; if (acc_dat[0] !== 32'hA5 || acc_cyc[0] !== c0 + 1) begin errors++; $display("FAIL blink_first got %h@%0d need a5@%0d", acc_dat[0], acc_cyc[0], c0 + 1); end
      checks++; if (acc_dat[1] !== 32'h5A) begin errors++; $display("FAIL blink_second got %h need 5a", acc_dat[1]); end
      checks++; if (acc_cyc[1] - acc_cyc[0] !== 5) begin errors++; $display("FAIL blink_stall_spacing got %0d need 5", acc_cyc[1] - acc_cyc[0]); end
      checks++; if (acc_dat[2] !== 32'hA5 || acc_cyc[2] - acc_cyc[1] !== 2) begin errors++; $display("FAIL blink_third got %h gap %0d need a5 gap 2", acc_dat[2], acc_cyc[2] - acc_cyc[1]); end
    end
  endtask

  task automatic test_static_p0();
    clear_log();
    cfg_write(2'd1, 32'd0);
    cfg_write(2'd2, 32'h3C);
    cfg_write(2'd0, 32'h1);
    repeat (12) tick();
    cfg_write(2'd0, 32'h0);
    repeat (3) tick();
    checks++; if (acc_dat.size() < 5) begin errors++; $display("FAIL static_count got %0d need >=5", acc_dat.size()); end
    for (int i = 0; i < 5 && i < acc_dat.size(); i++) begin
      checks++; if (acc_dat[i] !== 32'h3C) begin errors++; $display("FAIL static_data[%0d] got %h need 3c", i, acc_dat[i]); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 2) begin errors++; $display("FAIL static_spacing[%0d] got %0d need 2", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_push_count();
    cfg_write(2'd1, 32'd100);
    cfg_write(2'd2, 32'h01);
    cfg_write(2'd0, 32'h3);
    repeat (2) tick();
    checks++; if (m_chipselect !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL count_state got cs=%b busy=%b need cs=0 busy=1", m_chipselect, busy); end
    cfg_write(2'd3, 32'd0);
    checks++; if (m_chipselect !== 1'b1 || m_writedata !== 32'h02) begin errors++; $display("FAIL push_count_write got cs=%b d=%h need cs=1 d=02", m_chipselect, m_writedata); end
    cfg_write(2'd0, 32'h0);
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || pattern !== 8'h02) begin errors++; $display("FAIL push_count_end got busy=%b pat=%h need busy=0 pat=02", busy, pattern); end
  endtask

  task automatic test_reset_mid_write();
    cfg_write(2'd1, 32'd50);
    cfg_write(2'd2, 32'h11);
    m_waitrequest = 1'b1;
    cfg_write(2'd0, 32'h1);
    tick();
    checks++; if (m_chipselect !== 1'b1 || m_writedata !== 32'h11) begin errors++; $display("FAIL held_req got cs=%b d=%h need cs=1 d=11", m_chipselect, m_writedata); end
    s_address = 2'd3; #1;
    checks++; if (s_readdata !== 32'h0000_0201) begin errors++; $display("FAIL status_busy got %h need 00000201", s_readdata); end
    reset = 1'b1;
    tick();
    checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin errors++; $display("FAIL rst_mid_req got cs=%b wn=%b need cs=0 wn=1", m_chipselect, m_write_n); end
    checks++; if (busy !== 1'b0 || pattern !== 8'h00) begin errors++; $display("FAIL rst_mid_state got busy=%b pat=%h need busy=0 pat=00", busy, pattern); end
    reset = 1'b0;
    m_waitrequest = 1'b0;
    s_address = 2'd1; #1;
    checks++; if (s_readdata !== 32'd5_000_000) begin errors++; $display("FAIL rst_mid_period got %0d need 5000000", s_readdata); end
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_idle got busy=%b need 0", busy); end
  endtask

  initial begin
    test_reset();
    test_push_oneshot();
    test_walk();
    test_bounce();
    test_blink_stall();
    test_static_p0();
    test_push_count();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
